// File: rtl/dma_tx_bufcmd_queue.sv
// TX DMA buffer-command queue: parses 3-word commands into descriptors,
// queues them first-word-fall-through, and tracks posted/aired bursts.
module dma_tx_bufcmd_queue #(
  parameter int TIMESTAMP_BITS  = 49,
  parameter int RAM_ADDR_WIDTH  = 17,
  parameter int DATA_BITS       = 3,
  parameter int SAMPLES_WIDTH   = 13,
  parameter int BURSTS_BITS     = 5,
  parameter int FIFO_DEPTH_BITS = 4,
  parameter int PRECHARGE_THR   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                axis_cmd_data,
  input  logic                       axis_cmd_valid,
  output logic                       axis_cmd_ready,
  input  logic [31:0]                axis_control_data,
  input  logic                       axis_control_valid,
  output logic                       axis_control_ready,
  output logic [TIMESTAMP_BITS+BURSTS_BITS+SAMPLES_WIDTH+RAM_ADDR_WIDTH-DATA_BITS-1:0] m_bufcmd_data,
  output logic                       m_bufcmd_valid,
  input  logic                       m_bufcmd_ready,
  input  logic                       s_proc_idx_valid,
  output logic                       s_proc_idx_ready,
  output logic [1:0]                 fe_mute,
  output logic                       fe_format,
  output logic                       fe_swap,
  output logic                       txdma_active,
  output logic                       tx_buffprecharged,
  output logic [FIFO_DEPTH_BITS:0]   fifo_level,
  output logic [31:0]                m_stat_data
);

  localparam int BYTES_W = RAM_ADDR_WIDTH - DATA_BITS;
  localparam int D_W     = TIMESTAMP_BITS + BURSTS_BITS + SAMPLES_WIDTH + BYTES_W;
  localparam int DEPTH   = 2 ** FIFO_DEPTH_BITS;
  localparam int TSH_W   = TIMESTAMP_BITS - 32;
  localparam logic [FIFO_DEPTH_BITS:0] FULL_LVL = (FIFO_DEPTH_BITS+1)'(DEPTH);

  typedef enum logic [1:0] {W0 = 2'd0, W1 = 2'd1, W2 = 2'd2} pstate_t;

  pstate_t                    pstate_q, pstate_d;
  logic                       active_q, active_d;
  logic                       prech_q, prech_d;
  logic                       fmt_q, fmt_d;
  logic                       swap_q, swap_d;
  logic [1:0]                 mute_q, mute_d;
  logic [BURSTS_BITS-1:0]     bursts_q, bursts_d;
  logic [SAMPLES_WIDTH-1:0]   samples_q, samples_d;
  logic [BYTES_W-1:0]         bytes_q, bytes_d;
  logic [TSH_W-1:0]           tsh_q, tsh_d;
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_BITS:0]   level_q, level_d;
  logic [FIFO_DEPTH_BITS-1:0] sh_wr_q, sh_wr_d, sh_rd_q, sh_rd_d;
  logic [FIFO_DEPTH_BITS:0]   sh_lvl_q, sh_lvl_d;
  logic [BURSTS_BITS-1:0]     sub_q, sub_d;
  logic [7:0]                 posted_q, posted_d, aired_q, aired_d, err_q, err_d;
  logic [15:0]                since_q, since_d;

  logic [D_W-1:0]             mem_q [DEPTH];
  logic [BURSTS_BITS-1:0]     sh_mem_q [DEPTH];

  logic do_clear, do_stop, do_start, do_upd, flush;
  logic full, cmd_fire, w2_fire, push, bad, pop;
  logic sh_push, proc_cnt, air;
  logic [D_W-1:0] desc;
  logic [1:0] pstate_bits;
  logic unused_bits;

  assign unused_bits = ^{axis_control_data, axis_cmd_data};

  assign do_clear = axis_control_valid && axis_control_data[7];
  assign do_stop  = axis_control_valid && !axis_control_data[7] &&
                    (axis_control_data[1:0] == 2'b00) && active_q;
  assign do_start = axis_control_valid && !axis_control_data[7] &&
                    (axis_control_data[1:0] == 2'b11) && !active_q;
  assign do_upd   = axis_control_valid && !axis_control_data[7] && active_q &&
                    axis_control_data[11] && !do_stop;
  assign flush    = do_clear || do_stop;

  assign full           = (level_q == FULL_LVL);
  assign axis_cmd_ready = active_q && !((pstate_q == W2) && full);
  assign cmd_fire       = axis_cmd_valid && axis_cmd_ready;
  assign w2_fire        = cmd_fire && (pstate_q == W2) && !flush;
  assign push           = w2_fire && (bytes_q != '0);
  assign bad            = w2_fire && (bytes_q == '0);
  assign pop            = (level_q != '0) && m_bufcmd_ready && !flush;
  assign desc           = {tsh_q, axis_cmd_data, bursts_q, samples_q, bytes_q};

  // Bursts shadow outlives the main queue entry until the descriptor has aired.
  assign sh_push  = push && (sh_lvl_q != FULL_LVL);
  assign proc_cnt = s_proc_idx_valid && active_q && (sh_lvl_q != '0) && !flush;
  assign air      = proc_cnt && (sub_q == sh_mem_q[sh_rd_q]);

  always_comb begin
    pstate_d  = pstate_q;
    active_d  = active_q;
    fmt_d     = fmt_q;
    swap_d    = swap_q;
    mute_d    = mute_q;
    bursts_d  = bursts_q;
    samples_d = samples_q;
    bytes_d   = bytes_q;
    tsh_d     = tsh_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    sh_wr_d   = sh_wr_q;
    sh_rd_d   = sh_rd_q;
    sh_lvl_d  = sh_lvl_q;
    sub_d     = sub_q;
    posted_d  = posted_q;
    aired_d   = aired_q;
    err_d     = err_q;
    since_d   = since_q;

    if (cmd_fire) begin
      unique case (pstate_q)
        W0: begin
          bytes_d   = axis_cmd_data[BYTES_W-1:0];
          samples_d = axis_cmd_data[BYTES_W +: SAMPLES_WIDTH];
          bursts_d  = axis_cmd_data[BYTES_W+SAMPLES_WIDTH +: BURSTS_BITS];
          pstate_d  = W1;
        end
        W1: begin
          tsh_d    = axis_cmd_data[TSH_W-1:0];
          pstate_d = W2;
        end
        default: pstate_d = W0;
      endcase
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      posted_d = posted_q + 1'b1;
      since_d  = (since_q == '1) ? since_q : since_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    if (bad && (err_q != '1)) err_d = err_q + 1'b1;

    if (sh_push) sh_wr_d = sh_wr_q + 1'b1;
    if (air)     sh_rd_d = sh_rd_q + 1'b1;
    if (sh_push && !air)      sh_lvl_d = sh_lvl_q + 1'b1;
    else if (!sh_push && air) sh_lvl_d = sh_lvl_q - 1'b1;

    if (air) begin
      sub_d   = '0;
      aired_d = aired_q + 1'b1;
    end else if (proc_cnt) begin
      sub_d = sub_q + 1'b1;
    end

    if (do_start) begin
      active_d = 1'b1;
      fmt_d    = axis_control_data[3];
      mute_d   = {axis_control_data[8], axis_control_data[9]};
      swap_d   = axis_control_data[10];
      since_d  = '0;
    end
    if (do_upd) begin
      mute_d = {axis_control_data[8], axis_control_data[9]};
      swap_d = axis_control_data[10];
    end
    if (flush) begin
      active_d = 1'b0;
      pstate_d = W0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      sh_wr_d  = '0;
      sh_rd_d  = '0;
      sh_lvl_d = '0;
      sub_d    = '0;
    end
    if (do_clear) begin
      posted_d = '0;
      aired_d  = '0;
      err_d    = '0;
    end

    prech_d = active_d && (prech_q || (int'(since_d) >= PRECHARGE_THR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate_q  <= W0;
      active_q  <= 1'b0;
      prech_q   <= 1'b0;
      fmt_q     <= 1'b0;
      swap_q    <= 1'b0;
      mute_q    <= '0;
      bursts_q  <= '0;
      samples_q <= '0;
      bytes_q   <= '0;
      tsh_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sh_wr_q   <= '0;
      sh_rd_q   <= '0;
      sh_lvl_q  <= '0;
      sub_q     <= '0;
      posted_q  <= '0;
      aired_q   <= '0;
      err_q     <= '0;
      since_q   <= '0;
    end else begin
      pstate_q  <= pstate_d;
      active_q  <= active_d;
      prech_q   <= prech_d;
      fmt_q     <= fmt_d;
      swap_q    <= swap_d;
      mute_q    <= mute_d;
      bursts_q  <= bursts_d;
      samples_q <= samples_d;
      bytes_q   <= bytes_d;
      tsh_q     <= tsh_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sh_wr_q   <= sh_wr_d;
      sh_rd_q   <= sh_rd_d;
      sh_lvl_q  <= sh_lvl_d;
      sub_q     <= sub_d;
      posted_q  <= posted_d;
      aired_q   <= aired_d;
      err_q     <= err_d;
      since_q   <= since_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)    mem_q[wr_ptr_q]    <= desc;
    if (sh_push) sh_mem_q[sh_wr_q]  <= bursts_q;
  end

  // Storage is unreset, so the head is masked to keep the output clean when empty.
  assign m_bufcmd_valid     = (level_q != '0);
  assign m_bufcmd_data      = m_bufcmd_valid ? mem_q[rd_ptr_q] : '0;
  assign axis_control_ready = 1'b1;
  assign s_proc_idx_ready   = active_q;
  assign fe_mute            = mute_q;
  assign fe_format          = fmt_q;
  assign fe_swap            = swap_q;
  assign txdma_active       = active_q;
  assign tx_buffprecharged  = prech_q;
  assign fifo_level         = level_q;
  assign pstate_bits        = pstate_q;
  assign m_stat_data        = {err_q, aired_q, posted_q, 3'b000, full,
                               active_q, prech_q, pstate_bits};

endmodule

// File: tb/tb_dma_tx_bufcmd_queue.sv
// Scoreboard bench for dma_tx_bufcmd_queue: descriptors expected at command
// acceptance, compared as they leave the queue.
module tb_dma_tx_bufcmd_queue;

  localparam int DW = 81;

  logic          clk;
  logic          rst_n;
  logic [31:0]   axis_cmd_data;
  logic          axis_cmd_valid;
  logic          axis_cmd_ready;
  logic [31:0]   axis_control_data;
  logic          axis_control_valid;
  logic          axis_control_ready;
  logic [DW-1:0] m_bufcmd_data;
  logic          m_bufcmd_valid;
  logic          m_bufcmd_ready;
  logic          s_proc_idx_valid;
  logic          s_proc_idx_ready;
  logic [1:0]    fe_mute;
  logic          fe_format;
  logic          fe_swap;
  logic          txdma_active;
  logic          tx_buffprecharged;
  logic [4:0]    fifo_level;
  logic [31:0]   m_stat_data;

  dma_tx_bufcmd_queue #(
    .TIMESTAMP_BITS(49), .RAM_ADDR_WIDTH(17), .DATA_BITS(3), .SAMPLES_WIDTH(13),
    .BURSTS_BITS(5), .FIFO_DEPTH_BITS(4), .PRECHARGE_THR(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axis_cmd_data(axis_cmd_data), .axis_cmd_valid(axis_cmd_valid),
    .axis_cmd_ready(axis_cmd_ready),
    .axis_control_data(axis_control_data), .axis_control_valid(axis_control_valid),
    .axis_control_ready(axis_control_ready),
    .m_bufcmd_data(m_bufcmd_data), .m_bufcmd_valid(m_bufcmd_valid),
    .m_bufcmd_ready(m_bufcmd_ready),
    .s_proc_idx_valid(s_proc_idx_valid), .s_proc_idx_ready(s_proc_idx_ready),
    .fe_mute(fe_mute), .fe_format(fe_format), .fe_swap(fe_swap),
    .txdma_active(txdma_active), .tx_buffprecharged(tx_buffprecharged),
    .fifo_level(fifo_level), .m_stat_data(m_stat_data)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [DW-1:0] sb[$];
  logic [7:0] exp_posted = '0;
  logic [7:0] exp_err    = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2);
    logic [16:0] tsh;
    tsh = w1[16:0];
    return {tsh, w2, w0[31:27], w0[26:14], w0[13:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ctrl(input logic [31:0] d);
    axis_control_data  = d;
    axis_control_valid = 1'b1;
    tick();
    axis_control_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    axis_cmd_data  = w;
    axis_cmd_valid = 1'b1;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = axis_cmd_ready;
      tick();
      n++;
    end
    axis_cmd_valid = 1'b0;
    if (!acc) chk("cmd_timeout", 0, 1);
  endtask

  task automatic send_cmd(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    send_word(w0);
    send_word(w1);
    send_word(w2);
    if (w0[13:0] != 14'd0) begin
      sb.push_back(mk(w0, w1, w2));
      exp_posted = exp_posted + 8'd1;
    end else if (exp_err != 8'hFF) begin
      exp_err = exp_err + 8'd1;
    end
  endtask

  task automatic send_proc();
    s_proc_idx_valid = 1'b1;
    tick();
    s_proc_idx_valid = 1'b0;
  endtask

  // Every descriptor leaving the queue is matched against the scoreboard.
  always @(negedge clk) begin
    if (m_bufcmd_valid && m_bufcmd_ready) begin
      if (sb.size() == 0) chk("desc_unexpected", m_bufcmd_data, 0);
      else chk("desc", m_bufcmd_data, sb.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] w0;
    rst_n = 1'b0;
    axis_cmd_data = '0; axis_cmd_valid = 1'b0;
    axis_control_data = '0; axis_control_valid = 1'b0;
    m_bufcmd_ready = 1'b0; s_proc_idx_valid = 1'b0;

    #2;
    chk("rst_outputs", {m_bufcmd_data, m_bufcmd_valid, axis_cmd_ready, s_proc_idx_ready,
        fe_mute, fe_format, fe_swap, txdma_active, tx_buffprecharged, fifo_level,
        m_stat_data}, 0);
    chk("rst_ctrl_ready", axis_control_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", axis_cmd_ready, 0);

    // Basic descriptor
    send_ctrl(32'h003);
    chk("active", {txdma_active, s_proc_idx_ready, axis_cmd_ready, fe_mute, fe_format, fe_swap},
        7'b111_0000);
    chk("prech_before_post", tx_buffprecharged, 0);
    send_cmd(32'h0800_4010, 32'h0000_0001, 32'h0000_1000);
    chk("basic_level", fifo_level, 1);
    chk("basic_head", m_bufcmd_data, {17'h1, 32'h1000, 5'd1, 13'd1, 14'h10});
    chk("basic_posted", m_stat_data[15:8], 1);
    chk("basic_state", m_stat_data[4:0], 5'b0_1100);
    m_bufcmd_ready = 1'b1;
    tick(); tick();
    m_bufcmd_ready = 1'b0;
    chk("basic_drained", fifo_level, 0);

    // Airing: bursts=1 needs two proc pulses
    send_proc();
    chk("aired_after_1", m_stat_data[23:16], 0);
    send_proc();
    chk("aired_after_2", m_stat_data[23:16], 1);

    // Mute/swap update while active
    send_ctrl(32'hD01);
    chk("upd_fe", {txdma_active, fe_mute, fe_format, fe_swap}, 5'b1_10_0_1);

    // Zero-byte descriptor is dropped
    send_cmd(32'h0800_4000, 32'h5, 32'h6);
    chk("zero_err", m_stat_data[31:24], exp_err);
    chk("zero_posted", m_stat_data[15:8], exp_posted);
    chk("zero_parser_w0", {fifo_level, m_stat_data[1:0]}, 0);

    // Fill the queue, then hold W2 of a 17th descriptor
    for (int i = 0; i < 16; i++) begin
      w0 = (32'(i) << 14) | 32'(i + 1);
      send_cmd(w0, 32'(i), 32'hA000_0000 + 32'(i));
    end
    chk("full_level", fifo_level, 16);
    chk("full_flag", m_stat_data[4], 1);
    send_word(32'h0000_0077);
    send_word(32'h0001_FFFF);
    axis_cmd_data  = 32'hDEAD_BEEF;
    axis_cmd_valid = 1'b1;
    @(negedge clk);
    chk("full_w2_block", {axis_cmd_ready, m_stat_data[1:0]}, 3'b0_10);
    tick();
    m_bufcmd_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_still_block", axis_cmd_ready, 0);
    tick();
    m_bufcmd_ready = 1'b0;
    @(negedge clk);
    chk("after_pop_ready", axis_cmd_ready, 1);
    tick();
    axis_cmd_valid = 1'b0;
    sb.push_back(mk(32'h0000_0077, 32'h0001_FFFF, 32'hDEAD_BEEF));
    exp_posted = exp_posted + 8'd1;
    chk("refill_level", fifo_level, 16);
    chk("refill_posted", m_stat_data[15:8], exp_posted);
    m_bufcmd_ready = 1'b1;
    repeat (20) tick();
    m_bufcmd_ready = 1'b0;
    chk("drain_level", fifo_level, 0);
    chk("drain_all_seen", sb.size(), 0);

    // Stop mid-command with three queued
    for (int i = 0; i < 3; i++) send_cmd(32'h1000_4020 + 32'(i), 32'(i), 32'(i));
    send_word(32'h0800_4010);
    send_word(32'h0000_0003);
    chk("pre_stop", {fifo_level, m_stat_data[1:0]}, {5'd3, 2'd2});
    send_ctrl(32'h000);
    sb.delete();
    chk("stop", {txdma_active, tx_buffprecharged, fifo_level, axis_cmd_ready, m_bufcmd_valid},
        0);
    chk("stop_parser", m_stat_data[3:0], 0);
    send_ctrl(32'h20B);
    chk("restart_fe", {txdma_active, fe_mute, fe_format}, 4'b1_01_1);
    m_bufcmd_ready = 1'b1;
    send_cmd(32'h1800_8123, 32'h0000_ABCD, 32'h1234_5678);
    tick(); tick();
    m_bufcmd_ready = 1'b0;
    chk("restart_drained", fifo_level, 0);
    chk("restart_posted", m_stat_data[15:8], exp_posted);

    // Clear counters
    send_ctrl(32'h080);
    chk("clear", {m_stat_data[31:8], txdma_active}, 0);
    exp_posted = '0;
    exp_err = '0;

    // Asynchronous reset mid-command
    send_ctrl(32'h003);
    send_word(32'h0800_4010);
    chk("pre_rst_w1", m_stat_data[1:0], 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst", {m_bufcmd_data, m_bufcmd_valid, axis_cmd_ready, s_proc_idx_ready,
        fe_mute, fe_format, fe_swap, txdma_active, tx_buffprecharged, fifo_level,
        m_stat_data}, 0);
    tick();
    rst_n = 1'b1;
    sb.delete();
    m_bufcmd_ready = 1'b1;
    send_ctrl(32'h003);
    repeat (5) tick();
    chk("post_rst_empty", {m_bufcmd_valid, fifo_level, m_stat_data[1:0]}, 0);
    m_bufcmd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma_tx_bufcmd_queue.md
DMA_TX_BUFCMD_QUEUE -- requirements
Module: dma_tx_bufcmd_queue

Interface
REQ-001 Parameter TIMESTAMP_BITS, default 49; descriptor timestamp width; bit TIMESTAMP_BITS-1 is the no-ts flag.
REQ-002 Parameter RAM_ADDR_WIDTH, default 17; RAM byte-address width.
REQ-003 Parameter DATA_BITS, default 3; log2 of the bus word in bytes.
REQ-004 Parameter SAMPLES_WIDTH, default 13; per-burst sample-count width.
REQ-005 Parameter BURSTS_BITS, default 5; burst-count field width.
REQ-006 Parameter FIFO_DEPTH_BITS, default 4; queue depth is 2**FIFO_DEPTH_BITS.
REQ-007 Parameter PRECHARGE_THR, default 1; number of posted descriptors that asserts precharge.
REQ-008 Ports, in order: name, direction, width, meaning.
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous, active-low reset.
- axis_cmd_data / axis_cmd_valid / axis_cmd_ready: in/in/out, 32/1/1; 3-word new-style command stream.
- axis_control_data / axis_control_valid / axis_control_ready: in/in/out, 32/1/1; control word.
- m_bufcmd_data, out, D = TIMESTAMP_BITS+BURSTS_BITS+SAMPLES_WIDTH+RAM_ADDR_WIDTH-DATA_BITS; value is {ts, bursts, samples, bytes}.
- m_bufcmd_valid / m_bufcmd_ready: out/in, 1/1; descriptor handshake.
- s_proc_idx_valid / s_proc_idx_ready: in/out, 1/1; one burst aired.
- fe_mute, out, 2: front-end mute.
- fe_format, out, 1: front-end format.
- fe_swap, out, 1: front-end swap.
- txdma_active, out, 1: DMA active.
- tx_buffprecharged, out, 1: precharge reached.
- fifo_level, out, FIFO_DEPTH_BITS+1: queue occupancy.
- m_stat_data, out, 32: {cmd_err[7:0], aired[7:0], posted[7:0], 3'b0, fifo_full, state[3:0]}.

Function
REQ-009 axis_control_ready SHALL be 1 at all times.
REQ-010 Control [1:0]=11 while inactive SHALL set txdma_active and load fe_format=[3], fe_mute={[8],[9]}, fe_swap=[10].
REQ-011 Control [1:0]=00 while active SHALL clear txdma_active, flush the queue, return the parser to W0, and zero the burst sub-counter.
REQ-012 Control [7]=1 SHALL take priority over bits [1:0] and SHALL perform REQ-011 plus zero the posted, aired and cmd_err counters.
REQ-013 Control [11]=1 while active, with no start or stop, SHALL update fe_mute and fe_swap only.
REQ-014 The parser FSM SHALL have states W0, W1 and W2, advancing one state per accepted word and returning W2->W0.
- W0: {bursts[31:27], samples[26:14], bytes[13:0]} for the default parameters; fields are LSB-aligned to the parameter widths.
- W1: ts high, bits [TIMESTAMP_BITS-33:0].
- W2: ts[31:0].
REQ-015 axis_cmd_ready SHALL be 0 when inactive, and 0 in W2 while the queue is full; it SHALL be 1 otherwise.
REQ-016 Acceptance of W2 SHALL push the descriptor, visible at the queue head no earlier than the next cycle, unless bytes==0.
REQ-017 A descriptor with bytes==0 SHALL be dropped and SHALL increment cmd_err, saturating at 255.
REQ-018 A full queue SHALL block the push even if m_bufcmd_ready pops in the same cycle; a simultaneous push and pop when not full SHALL leave fifo_level unchanged.
REQ-019 The queue SHALL be first-word-fall-through, with m_bufcmd_valid = (fifo_level != 0).
REQ-020 Each push SHALL increment posted, mod 256.
REQ-021 s_proc_idx_ready SHALL equal txdma_active.
REQ-022 A burst sub-counter SHALL count accepted proc pulses; when it equals bursts+1 of the oldest un-aired descriptor, aired SHALL increment (mod 256) and the sub-counter SHALL clear.
REQ-023 The engine SHALL hold a bursts field for each descriptor until it is aired, using an internal shadow queue of the same depth.
REQ-024 tx_buffprecharged SHALL set when the number of posts since activation reaches PRECHARGE_THR, and SHALL clear when inactive.
REQ-025 state[3:0] in m_stat_data SHALL be {txdma_active, tx_buffprecharged, parser state[1:0]}, with W0=0, W1=1, W2=2.

Reset
REQ-026 While rst_n is low, regardless of clk:
- all outputs SHALL be 0 except axis_control_ready;
- the parser SHALL be in W0;
- the queue SHALL be empty and all counters SHALL be 0.
REQ-027 Reset asserted mid-command SHALL discard partial words, and no descriptor SHALL emerge after release.

Verification
REQ-028 Start 0x003, then words 0x0800_4010, 0x0000_0001, 0x0000_1000 -> one descriptor: bursts=1, samples=0x1, bytes=0x10, ts=0x1_0000_1000; posted=1; tx_buffprecharged=1.
REQ-029 Fill 16 descriptors with m_bufcmd_ready=0 -> fifo_level=16 and axis_cmd_ready=0 in W2; pulse m_bufcmd_ready once -> the 17th descriptor is accepted on the next cycle.
REQ-030 W0 with bytes=0 -> no push, cmd_err=1, posted unchanged, parser back to W0.
REQ-031 Descriptor with bursts=1, then 2 proc pulses -> aired goes 0 after the first pulse and 1 after the second.
REQ-032 Stop 0x000 after W1 with 3 queued -> txdma_active=0, fifo_level=0, axis_cmd_ready=0; a subsequent start resumes at W0.
REQ-033 Drop rst_n mid-W1 -> all outputs 0 immediately, without a clk edge.
